// File: rtl/uart_watch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_watch_pkg
//  Description : Shared definitions for the time report transmitter.
//                - state_t : report FSM state encoding
//                - ASCII_* : message punctuation and digit base
//                - msg_len : message length for a given SEND_CSEC setting
//                - sat99   : clamp a binary value to the 0..99 display range
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_watch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SNAP = 3'd1,
        ST_CONV = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam logic [6:0] BCD_MAX     = 7'd99;

    // "HH:MM:SS.CC\r\n" is 13 bytes; dropping ".CC" leaves 10.
    function automatic int unsigned msg_len(input int send_csec);
        return (send_csec != 0) ? 32'd13 : 32'd10;
    endfunction

    // Two display digits cannot show more than 99.
    function automatic logic [6:0] sat99(input logic [31:0] v);
        return (v > 32'd99) ? BCD_MAX : v[6:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_99.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_99
//  Description : Combinational binary (0..99) to two-digit BCD converter.
//  Ports       : bin  [6:0] in  - binary value, caller guarantees <= 99
//                tens [3:0] out - tens digit
//                ones [3:0] out - ones digit
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_99 (
    input  logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    // Constant divisor: synthesis reduces this to a small lookup network.
    always_comb begin
        tens = 4'(bin / 7'd10);
        ones = 4'(bin % 7'd10);
    end

endmodule
`default_nettype wire

// File: rtl/time_report_tx.sv
`default_nettype none
// ============================================================================
//  Module      : time_report_tx
//  Description : Formats a snapshot of the watch time as ASCII
//                "HH:MM:SS.CC\r\n" (or "HH:MM:SS\r\n") and writes it one
//                byte per accepted cycle into the UART TX FIFO.
//  Ports       : clk          in  - system clock
//                reset        in  - asynchronous active-low reset
//                hour/min/sec/csec in - current time, binary
//                req          in  - 1-cycle report request
//                auto_en,tick in  - periodic report enable and strobe
//                tx_fifo_full in  - TX FIFO full, stalls the byte stream
//                tx_wr_en     out - FIFO write strobe
//                tx_wr_data   out - ASCII byte (8'h00 outside SEND)
//                busy         out - report in progress (SNAP..SEND)
//                done         out - 1-cycle pulse after the last byte
//  Revision    : 1.0 - initial release
// ============================================================================
module time_report_tx
    import uart_watch_pkg::*;
#(
    parameter int SEND_CSEC = 1,
    parameter int HOUR_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [HOUR_W-1:0] hour,
    input  logic [5:0]        min,
    input  logic [5:0]        sec,
    input  logic [6:0]        csec,
    input  logic              req,
    input  logic              auto_en,
    input  logic              tick,
    input  logic              tx_fifo_full,
    output logic              tx_wr_en,
    output logic [7:0]        tx_wr_data,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0] LAST_IDX = 4'(msg_len(SEND_CSEC) - 1);

    // Field order in the snapshot arrays: 0 hour, 1 min, 2 sec, 3 csec.
    state_t     state_q, state_d;
    logic       pending_q, pending_d;
    logic [3:0] idx_q, idx_d;
    logic [6:0] snap_q [4];
    logic [6:0] snap_d [4];
    logic [7:0] bcd_q  [4];   // {tens, ones}
    logic [7:0] bcd_d  [4];
    logic [3:0] bcd_tens [4];
    logic [3:0] bcd_ones [4];

    logic       trigger;
    logic [7:0] msg_byte;

    for (genvar g = 0; g < 4; g++) begin : g_bcd
        bin2bcd_99 u_bin2bcd (
            .bin  (snap_q[g]),
            .tens (bcd_tens[g]),
            .ones (bcd_ones[g])
        );
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        bcd_d     = bcd_q;

        // req and tick together still count as a single trigger.
        trigger = req | (auto_en & tick);

        // Outside IDLE a trigger is remembered once; extra ones are dropped.
        // This also covers a trigger landing in the DONE cycle.
        if (state_q != ST_IDLE && trigger) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (trigger || pending_q) begin
                    state_d   = ST_SNAP;
                    pending_d = 1'b0;
                end
            end
            ST_SNAP: begin
                snap_d[0] = sat99(32'(hour));
                snap_d[1] = sat99(32'(min));
                snap_d[2] = sat99(32'(sec));
                snap_d[3] = sat99(32'(csec));
                state_d   = ST_CONV;
            end
            ST_CONV: begin
                for (int i = 0; i < 4; i++) begin
                    bcd_d[i] = {bcd_tens[i], bcd_ones[i]};
                end
                idx_d   = 4'd0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                // Advance only on a write the FIFO actually takes.
                if (!tx_fifo_full) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 4'd0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Byte mux: message position -> ASCII from the registered BCD digits
    // ------------------------------------------------------------------
    always_comb begin
        msg_byte = 8'h00;
        case (idx_q)
            4'd0: msg_byte = ASCII_0 + {4'd0, bcd_q[0][7:4]};
            4'd1: msg_byte = ASCII_0 + {4'd0, bcd_q[0][3:0]};
            4'd2: msg_byte = ASCII_COLON;
            4'd3: msg_byte = ASCII_0 + {4'd0, bcd_q[1][7:4]};
            4'd4: msg_byte = ASCII_0 + {4'd0, bcd_q[1][3:0]};
            4'd5: msg_byte = ASCII_COLON;
            4'd6: msg_byte = ASCII_0 + {4'd0, bcd_q[2][7:4]};
            4'd7: msg_byte = ASCII_0 + {4'd0, bcd_q[2][3:0]};
            default: begin
                if (SEND_CSEC != 0) begin
                    case (idx_q)
                        4'd8:    msg_byte = ASCII_DOT;
                        4'd9:    msg_byte = ASCII_0 + {4'd0, bcd_q[3][7:4]};
                        4'd10:   msg_byte = ASCII_0 + {4'd0, bcd_q[3][3:0]};
                        4'd11:   msg_byte = ASCII_CR;
                        4'd12:   msg_byte = ASCII_LF;
                        default: msg_byte = 8'h00;
                    endcase
                end else begin
                    case (idx_q)
                        4'd8:    msg_byte = ASCII_CR;
                        4'd9:    msg_byte = ASCII_LF;
                        default: msg_byte = 8'h00;
                    endcase
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state so they drop at reset
    // ------------------------------------------------------------------
    always_comb begin
        tx_wr_en   = (state_q == ST_SEND) && !tx_fifo_full;
        tx_wr_data = (state_q == ST_SEND) ? msg_byte : 8'h00;
        busy       = (state_q == ST_SNAP) || (state_q == ST_CONV) ||
                     (state_q == ST_SEND);
        done       = (state_q == ST_DONE);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            idx_q     <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                snap_q[i] <= 7'd0;
                bcd_q[i]  <= 8'd0;
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            bcd_q     <= bcd_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_time_report_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_report_tx
//  Description : Self-checking bench for time_report_tx. Expected bytes are
//                queued when a report is triggered and compared as the DUT
//                writes them. A second instance with SEND_CSEC=0 covers the
//                10-byte format.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_time_report_tx;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] hour;
    logic [5:0] min, sec;
    logic [6:0] csec;
    logic       req, req10, auto_en, tick, tx_fifo_full, full10;
    logic       tx_wr_en, busy, done;
    logic [7:0] tx_wr_data;
    logic       wr_en10, busy10, done10;
    logic [7:0] data10;

    int checks = 0;
    int errors = 0;
    int wr_count = 0, done_count = 0;
    int wr10_count = 0, done10_count = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp10_q[$];

    time_report_tx #(.SEND_CSEC(1), .HOUR_W(5)) dut (
        .clk(clk), .reset(reset), .hour(hour), .min(min), .sec(sec),
        .csec(csec), .req(req), .auto_en(auto_en), .tick(tick),
        .tx_fifo_full(tx_fifo_full), .tx_wr_en(tx_wr_en),
        .tx_wr_data(tx_wr_data), .busy(busy), .done(done)
    );

    time_report_tx #(.SEND_CSEC(0), .HOUR_W(5)) dut10 (
        .clk(clk), .reset(reset), .hour(hour), .min(min), .sec(sec),
        .csec(csec), .req(req10), .auto_en(1'b0), .tick(tick),
        .tx_fifo_full(full10), .tx_wr_en(wr_en10),
        .tx_wr_data(data10), .busy(busy10), .done(done10)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void put(input bit ten, input logic [7:0] b);
        if (ten) exp10_q.push_back(b);
        else     exp_q.push_back(b);
    endfunction

    // Reference message for a time value; fields above 99 show as 99.
    function automatic void push_msg(input bit ten, input int h, input int m,
                                     input int s, input int c);
        int v[4];
        v = '{h, m, s, c};
        for (int i = 0; i < 4; i++) if (v[i] > 99) v[i] = 99;
        put(ten, 8'(48 + v[0] / 10)); put(ten, 8'(48 + v[0] % 10)); put(ten, ":");
        put(ten, 8'(48 + v[1] / 10)); put(ten, 8'(48 + v[1] % 10)); put(ten, ":");
        put(ten, 8'(48 + v[2] / 10)); put(ten, 8'(48 + v[2] % 10));
        if (!ten) begin
            put(ten, "."); put(ten, 8'(48 + v[3] / 10)); put(ten, 8'(48 + v[3] % 10));
        end
        put(ten, 8'h0D); put(ten, 8'h0A);
    endfunction

    // Scoreboard: every write is compared with the oldest expected byte.
    always @(negedge clk) begin
        if (tx_wr_en) begin
            wr_count++;
            if (exp_q.size() == 0) chk("unexpected_byte", {24'd0, tx_wr_data}, 32'hFFFF_FFFF);
            else                   chk("byte", {24'd0, tx_wr_data}, {24'd0, exp_q.pop_front()});
        end
        if (wr_en10) begin
            wr10_count++;
            if (exp10_q.size() == 0) chk("unexpected_byte10", {24'd0, data10}, 32'hFFFF_FFFF);
            else                     chk("byte10", {24'd0, data10}, {24'd0, exp10_q.pop_front()});
        end
        if (done)   done_count++;
        if (done10) done10_count++;
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_req();
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic set_time(input int h, input int m, input int s, input int c);
        hour = 5'(h); min = 6'(m); sec = 6'(s); csec = 7'(c);
    endtask

    task automatic wait_first_byte(output int n);
        n = 0;
        while (!tx_wr_en && n < 20) begin @(posedge clk); #1; n++; end
    endtask

    task automatic wait_done_cnt(input int target, input int max);
        for (int i = 0; i < max; i++) begin
            if (done_count >= target) break;
            @(posedge clk); #1;
        end
        chk("done_count", done_count, target);
    endtask

    initial begin
        int n, cnt, base_done, base_wr;

        reset = 1'b0; req = 1'b0; req10 = 1'b0; auto_en = 1'b0; tick = 1'b0;
        tx_fifo_full = 1'b0; full10 = 1'b0;
        set_time(0, 0, 0, 0);
        idle(3);
        chk("rst_wr_en", tx_wr_en, 0);
        chk("rst_data",  tx_wr_data, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        reset = 1'b1;
        idle(2);

        // 1: basic report, latency and back-to-back bytes
        set_time(12, 34, 56, 78);
        push_msg(0, 12, 34, 56, 78);
        req = 1'b1;
        n = 0;
        while (!tx_wr_en && n < 20) begin
            @(posedge clk); #1; n++;
            req = 1'b0;
        end
        chk("latency", n, 3);
        chk("busy_send", busy, 1);
        cnt = 0;
        while (tx_wr_en && cnt < 20) begin cnt++; @(posedge clk); #1; end
        chk("burst_len", cnt, 13);
        chk("done_after_lf", done, 1);
        chk("busy_at_done", busy, 0);
        idle(1);
        chk("done_one_cycle", done, 0);

        // 2: FIFO full for 5 cycles at idx=4
        idle(3);
        base_wr = wr_count;
        base_done = done_count;
        push_msg(0, 12, 34, 56, 78);
        send_req();
        wait_first_byte(n);
        idle(4);
        tx_fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_wr_en", tx_wr_en, 0);
            chk("stall_busy", busy, 1);
            @(posedge clk); #1;
        end
        tx_fifo_full = 1'b0;
        wait_done_cnt(base_done + 1, 40);
        chk("stall_bytes", wr_count - base_wr, 13);

        // 3: time changes during SEND are ignored
        idle(3);
        base_done = done_count;
        push_msg(0, 12, 34, 56, 78);
        send_req();
        wait_first_byte(n);
        idle(3);
        set_time(0, 0, 0, 0);
        wait_done_cnt(base_done + 1, 40);
        chk("snap_q_empty", exp_q.size(), 0);

        // 4: three requests during one report -> exactly one extra report
        idle(3);
        base_done = done_count;
        base_wr = wr_count;
        set_time(1, 2, 3, 4);
        push_msg(0, 1, 2, 3, 4);
        send_req();
        idle(4);
        send_req();
        idle(2);
        send_req();
        set_time(5, 6, 7, 8);
        push_msg(0, 5, 6, 7, 8);
        idle(2);
        send_req();
        wait_done_cnt(base_done + 2, 80);
        idle(30);
        chk("pend_done_total", done_count - base_done, 2);
        chk("pend_bytes", wr_count - base_wr, 26);

        // 5: periodic ticks, one coinciding with req; csec 127 saturates
        base_done = done_count;
        auto_en = 1'b1;
        for (int t = 0; t < 3; t++) begin
            idle(80);
            case (t)
                0: begin set_time(10, 20, 30, 40); push_msg(0, 10, 20, 30, 40); end
                1: begin set_time(23, 59, 59, 99); push_msg(0, 23, 59, 59, 99); end
                default: begin set_time(31, 45, 0, 127); push_msg(0, 31, 45, 0, 127); end
            endcase
            tick = 1'b1;
            if (t == 1) req = 1'b1;
            @(posedge clk); #1;
            tick = 1'b0; req = 1'b0;
            wait_done_cnt(base_done + t + 1, 40);
        end
        auto_en = 1'b0;
        idle(40);
        chk("tick_reports", done_count - base_done, 3);

        // 6: async reset at idx=6, then a clean report
        set_time(12, 34, 56, 78);
        push_msg(0, 12, 34, 56, 78);
        send_req();
        wait_first_byte(n);
        idle(6);
        reset = 1'b0;
        #1;
        chk("abort_wr_en", tx_wr_en, 0);
        chk("abort_data", tx_wr_data, 0);
        chk("abort_busy", busy, 0);
        chk("abort_left", exp_q.size(), 7);
        exp_q.delete();
        idle(2);
        reset = 1'b1;
        idle(2);
        base_done = done_count;
        base_wr = wr_count;
        push_msg(0, 12, 34, 56, 78);
        send_req();
        wait_done_cnt(base_done + 1, 40);
        chk("post_rst_bytes", wr_count - base_wr, 13);

        // SEND_CSEC=0 build: "09:08:07\r\n"
        set_time(9, 8, 7, 65);
        push_msg(1, 9, 8, 7, 65);
        req10 = 1'b1;
        @(posedge clk); #1;
        req10 = 1'b0;
        for (int i = 0; i < 40 && done10_count == 0; i++) begin @(posedge clk); #1; end
        chk("done10", done10_count, 1);
        chk("bytes10", wr10_count, 10);
        idle(2);
        chk("busy10_idle", busy10, 0);

        idle(5);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("exp10_q_drained", exp10_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
